// File: rtl/q_argmax_scan.sv
// Sequential argmax over an external Q-value mux: drives sel one entry per
// cycle, tracks the running maximum of din, and publishes index/value on done.
module q_argmax_scan #(
   parameter int DATA_W    = 16,
   parameter int SEL_W     = 4,
   parameter int N_ENTRIES = 16,
   parameter bit SIGNED    = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [SEL_W-1:0]  sel,
   input  logic [DATA_W-1:0] din,
   output logic              busy,
   output logic              done,
   output logic [SEL_W-1:0]  max_idx,
   output logic [DATA_W-1:0] max_val
);

   // state  | meaning
   // S_IDLE | waiting for start, sel parked at 0
   // S_SCAN | one mux entry compared per cycle
   // S_DONE | one-cycle done pulse, results valid
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_ENTRIES - 1);

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [SEL_W-1:0]    best_idx_q, best_idx_d;
   logic [DATA_W-1:0]   best_val_q, best_val_d;
   logic [SEL_W-1:0]    max_idx_q, max_idx_d;
   logic [DATA_W-1:0]   max_val_q, max_val_d;
   logic                din_gt;
   logic [SEL_W-1:0]    cand_idx;
   logic [DATA_W-1:0]   cand_val;

   always_comb begin
      if (SIGNED) din_gt = $signed(din) > $signed(best_val_q);
      else        din_gt = din > best_val_q;
   end

   // Entry 0 seeds the running best; strict compare keeps the lowest index on ties.
   always_comb begin
      if (sel_q == '0 || din_gt) begin
         cand_idx = sel_q;
         cand_val = din;
      end else begin
         cand_idx = best_idx_q;
         cand_val = best_val_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      best_idx_d = best_idx_q;
      best_val_d = best_val_q;
      max_idx_d  = max_idx_q;
      max_val_d  = max_val_q;
      case (state_q)
         S_IDLE: begin
            sel_d = '0;
            if (start) state_d = S_SCAN;
         end
         S_SCAN: begin
            best_idx_d = cand_idx;
            best_val_d = cand_val;
            if (sel_q == LAST_SEL) begin
               max_idx_d = cand_idx;
               max_val_d = cand_val;
               sel_d     = '0;
               state_d   = S_DONE;
            end else begin
               sel_d = sel_q + SEL_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sel_q      <= '0;
         best_idx_q <= '0;
         best_val_q <= '0;
         max_idx_q  <= '0;
         max_val_q  <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         best_idx_q <= best_idx_d;
         best_val_q <= best_val_d;
         max_idx_q  <= max_idx_d;
         max_val_q  <= max_val_d;
      end
   end

   assign sel     = sel_q;
   assign busy    = (state_q == S_SCAN);
   assign done    = (state_q == S_DONE);
   assign max_idx = max_idx_q;
   assign max_val = max_val_q;

endmodule
